// File: rtl/fma_exp_pipe_if.sv
// Handshake bundle for the FMA exponent pipe: unpacked operand exponents in, exponent results out.
// The master side feeds operands and accepts results; the slave side is the pipe itself.
interface fma_exp_pipe_if #(
    parameter int unsigned NE = 11
);
    logic          in_valid;
    logic          in_ready;
    logic          Fmt;
    logic [NE-1:0] Xe;
    logic [NE-1:0] Ye;
    logic [NE-1:0] Ze;
    logic          XZero;
    logic          YZero;
    logic          ZZero;
    logic          out_valid;
    logic          out_ready;
    logic [NE+1:0] Pe;
    logic [NE+1:0] Dexp;
    logic          KillProd;
    logic          KillZ;
    logic          POvf;
    logic          PUfl;

    modport master (
        output in_valid, Fmt, Xe, Ye, Ze, XZero, YZero, ZZero, out_ready,
        input  in_ready, out_valid, Pe, Dexp, KillProd, KillZ, POvf, PUfl
    );

    modport slave (
        input  in_valid, Fmt, Xe, Ye, Ze, XZero, YZero, ZZero, out_ready,
        output in_ready, out_valid, Pe, Dexp, KillProd, KillZ, POvf, PUfl
    );
endinterface

// File: rtl/fma_exp_pipe.sv
// Pipelined FMA exponent path: biased product exponent, product-to-addend difference and kill/range flags,
// carried through LAT bubble-collapsing valid/ready register stages.
module fma_exp_pipe #(
    parameter int unsigned NE    = 11,
    parameter int unsigned BIAS0 = 1023,
    parameter int unsigned BIAS1 = 127,
    parameter int unsigned LAT   = 2,
    parameter int          KTH   = 55
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    fma_exp_pipe_if.slave bus
);
    localparam int unsigned EW = NE + 2;
    localparam int unsigned PW = 2 * EW + 4;
    localparam logic signed [EW-1:0] KTH_S  = EW'(KTH);
    localparam logic signed [EW-1:0] OVF_TH = EW'((2 ** NE) - 1);

    logic [NE-1:0] w_bias;
    logic [EW-1:0] w_pe;
    logic [EW-1:0] w_dexp;
    logic          w_kill_prod;
    logic          w_kill_z;
    logic          w_povf;
    logic          w_pufl;
    logic [PW-1:0] w_payload;

    always_comb begin
        w_bias      = bus.Fmt ? NE'(BIAS1) : NE'(BIAS0);
        w_kill_prod = bus.XZero | bus.YZero;
        w_pe        = w_kill_prod ? '0 : ({2'b00, bus.Xe} + {2'b00, bus.Ye} - {2'b00, w_bias});
        w_dexp      = w_pe - {2'b00, bus.Ze};
        w_kill_z    = bus.ZZero | ($signed(w_dexp) > KTH_S);
        w_povf      = !w_kill_prod & ($signed(w_pe) >= OVF_TH);
        w_pufl      = !w_kill_prod & (w_pe[EW-1] | (w_pe == '0));
        w_payload   = {w_pe, w_dexp, w_kill_prod, w_kill_z, w_povf, w_pufl};
    end

    logic [LAT-1:0] r_valid;
    logic [PW-1:0]  r_data [LAT];
    logic [LAT-1:0] w_load;
    logic           w_acc;

    // The chained "empty or advancing" ready collapses to: out_ready, or any empty stage at or after i.
    always_comb begin
        w_load = '0;
        w_acc  = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            w_acc = bus.out_ready;
            for (int unsigned j = i; j < LAT; j++) begin
                w_acc = w_acc | !r_valid[j];
            end
            w_load[i] = w_acc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (flush) begin
                r_valid[0] <= 1'b0;
            end else if (w_load[0]) begin
                r_valid[0] <= bus.in_valid;
            end
            if (w_load[0]) begin
                r_data[0] <= w_payload;
            end
            for (int unsigned i = 1; i < LAT; i++) begin
                if (flush) begin
                    r_valid[i] <= 1'b0;
                end else if (w_load[i]) begin
                    r_valid[i] <= r_valid[i-1];
                end
                if (w_load[i]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign bus.in_ready  = w_load[0];
    assign bus.out_valid = r_valid[LAT-1];
    assign {bus.Pe, bus.Dexp, bus.KillProd, bus.KillZ, bus.POvf, bus.PUfl} = r_data[LAT-1];
endmodule

// File: tb/tb_fma_exp_pipe.sv
// Bench for fma_exp_pipe: directed corner cases plus randomized handshake traffic against an integer model.
module tb_fma_exp_pipe;
    localparam int unsigned NE  = 11;
    localparam int unsigned LAT = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic flush   = 1'b0;

    fma_exp_pipe_if #(.NE(NE)) bus ();

    fma_exp_pipe #(
        .NE   (NE),
        .BIAS0(1023),
        .BIAS1(127),
        .LAT  (LAT),
        .KTH  (55)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_err  = 0;
    int n_acc  = 0;
    int n_out  = 0;
    int n_drop = 0;

    logic [29:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [29:0] prev_pl    = '0;
    logic [29:0] w_obs;

    assign w_obs = {bus.Pe, bus.Dexp, bus.KillProd, bus.KillZ, bus.POvf, bus.PUfl};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, truncated to the 13-bit result width at the end.
    function automatic logic [29:0] ref_model(input logic fmt, input int xe, input int ye, input int ze,
                                              input logic xz, input logic yz, input logic zz);
        int   pe;
        int   dexp;
        logic kp, kz, ov, uf;
        kp   = xz | yz;
        pe   = kp ? 0 : xe + ye - (fmt ? 127 : 1023);
        dexp = pe - ze;
        kz   = zz || (dexp > 55);
        ov   = !kp && (pe >= 2047);
        uf   = !kp && (pe <= 0);
        return {13'(pe), 13'(dexp), kp, kz, ov, uf};
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            n_drop += exp_q.size();
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_payload", w_obs, prev_pl);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("q_nonempty", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("out_data", w_obs, exp_q.pop_front());
                    n_out++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready && !flush;
            prev_pl    = w_obs;
            if (flush) begin
                n_drop += exp_q.size();
                exp_q.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_model(bus.Fmt, int'(bus.Xe), int'(bus.Ye), int'(bus.Ze),
                                          bus.XZero, bus.YZero, bus.ZZero));
                n_acc++;
            end
        end
    end

    task automatic set_op(input logic fmt, input logic [10:0] xe, input logic [10:0] ye, input logic [10:0] ze,
                          input logic xz, input logic yz, input logic zz);
        bus.Fmt = fmt; bus.Xe = xe; bus.Ye = ye; bus.Ze = ze;
        bus.XZero = xz; bus.YZero = yz; bus.ZZero = zz;
    endtask

    task automatic rand_op();
        logic fmt;
        fmt = 1'($urandom % 2);
        set_op(fmt,
               11'(fmt ? $urandom_range(0, 255) : $urandom_range(0, 2047)),
               11'(fmt ? $urandom_range(0, 255) : $urandom_range(0, 2047)),
               11'(fmt ? $urandom_range(0, 255) : $urandom_range(0, 2047)),
               ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0);
    endtask

    // Single transaction into an empty pipe with out_ready=1; called just after a rising edge.
    task automatic one_shot(input string tag, input logic fmt, input logic [10:0] xe, input logic [10:0] ye,
                            input logic [10:0] ze, input logic xz, input logic yz, input logic zz,
                            input logic [12:0] epe, input logic [12:0] edx, input logic [3:0] efl);
        set_op(fmt, xe, ye, ze, xz, yz, zz);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, bus.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_Pe"}, bus.Pe, epe);
        chk({tag, "_Dexp"}, bus.Dexp, edx);
        chk({tag, "_flags"}, {bus.KillProd, bus.KillZ, bus.POvf, bus.PUfl}, efl);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   guard;

        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        set_op(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_payload", w_obs, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid_post", bus.out_valid, 0);
        @(posedge clk); #1;

        one_shot("basic",  1'b0, 11'd1023, 11'd1023, 11'd1023, 1'b0, 1'b0, 1'b0, 13'd1023, 13'd0,     4'b0000);
        one_shot("zprod",  1'b0, 11'd1000, 11'd1000, 11'd5,    1'b1, 1'b0, 1'b0, 13'd0,    13'h1FFB,  4'b1000);
        one_shot("narrow", 1'b1, 11'd127,  11'd130,  11'd0,    1'b0, 1'b0, 1'b1, 13'd130,  13'd130,   4'b0100);
        one_shot("nkill",  1'b1, 11'd127,  11'd130,  11'd10,   1'b0, 1'b0, 1'b0, 13'd130,  13'd120,   4'b0100);
        one_shot("povf",   1'b0, 11'd2046, 11'd2046, 11'd0,    1'b0, 1'b0, 1'b0, 13'd3069, 13'd3069,  4'b0110);
        one_shot("pufl",   1'b0, 11'd1,    11'd1,    11'd0,    1'b0, 1'b0, 1'b0, 13'h1C03, 13'h1C03,  4'b0001);

        // Backpressure: six transactions offered while the sink stalls for five cycles.
        bus.out_ready = 1'b0;
        sent = 0;
        rand_op();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, (c < 2));
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 6) rand_op(); else bus.in_valid = 1'b0;
            end
        end
        bus.out_ready = 1'b1;
        guard = 0;
        while (sent < 6 && guard < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 6) rand_op(); else bus.in_valid = 1'b0;
            end
            guard++;
        end
        chk("bp_sent", sent, 6);
        drain("bp_drain");

        // Flush with two in flight and a new offer that must not be captured.
        rand_op(); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        rand_op();
        @(posedge clk); #1;
        rand_op();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_full", bus.out_valid, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("fl_empty", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        chk("fl_queue", exp_q.size(), 0);

        // Randomized traffic with random sink stalls.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (!bus.in_valid || acc) begin
                if ($urandom % 10 < 7) begin
                    rand_op();
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom % 10 < 7);
        end
        drain("rand_drain");

        // Asynchronous reset mid-stream.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_op(); bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        #2;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_payload", w_obs, 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_idle", bus.out_valid, 0);
        @(posedge clk); #1;

        one_shot("post_rst", 1'b0, 11'd1500, 11'd600, 11'd1000, 1'b0, 1'b0, 1'b0, 13'd1077, 13'd77, 4'b0100);
        chk("conservation", n_out + n_drop, n_acc);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
